// File: rtl/phivers_link_arbiter.sv
// Packet round-robin arbiter sharing one Phivers link among NPORTS requesters.
// Optional stall watchdog: define PHIVERS_ARB_STALL_WDT_EN.
module phivers_link_arbiter #(
  parameter int NPORTS    = 4,
  parameter int STALL_MAX = 64
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NPORTS-1:0]        tx_i,
  output logic [NPORTS-1:0]        cr_tx_o,
  input  logic [NPORTS-1:0]        eop_tx_i,
  input  logic [NPORTS*32-1:0]     data_tx_i,
  output logic                     rx_o,
  input  logic                     cr_rx_i,
  output logic                     eop_rx_o,
  output logic [31:0]              data_rx_o,
  output logic [NPORTS-1:0]        grant_o,
  output logic                     busy_o,
  output logic                     stall_o
);

  localparam int PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;

  typedef enum logic {IDLE, BUSY} state_e;

  state_e            state_q, state_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [NPORTS-1:0] grant_q, grant_d;
  logic              win_vld;
  logic [PW-1:0]     win_idx;
  logic [PW-1:0]     scan_idx;
  logic              busy;
  logic              xfer_eop;
  logic [31:0]       data_arr [NPORTS];

  for (genvar k = 0; k < NPORTS; k++) begin : g_unpack
    assign data_arr[k] = data_tx_i[32*k +: 32];
  end

  assign busy    = (state_q == BUSY);
  assign busy_o  = busy;
  assign grant_o = grant_q;

  // Scan ptr+1 .. ptr+NPORTS so the last winner has lowest priority.
  always_comb begin
    int j;
    j        = 0;
    win_vld  = 1'b0;
    win_idx  = '0;
    scan_idx = '0;
    for (int i = 1; i <= NPORTS; i++) begin
      j = int'(ptr_q) + i;
      if (j >= NPORTS) j = j - NPORTS;
      scan_idx = PW'(j);
      if (!win_vld && tx_i[scan_idx]) begin
        win_vld = 1'b1;
        win_idx = scan_idx;
      end
    end
  end

  always_comb begin
    rx_o      = 1'b0;
    eop_rx_o  = 1'b0;
    data_rx_o = '0;
    cr_tx_o   = '0;
    if (busy) begin
      rx_o      = tx_i[ptr_q];
      eop_rx_o  = eop_tx_i[ptr_q];
      data_rx_o = data_arr[ptr_q];
      cr_tx_o   = grant_q & {NPORTS{cr_rx_i}};
    end
  end

  assign xfer_eop = rx_o & cr_rx_i & eop_rx_o;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    unique case (state_q)
      IDLE: begin
        if (win_vld) begin
          state_d = BUSY;
          ptr_d   = win_idx;
          grant_d = {{(NPORTS-1){1'b0}}, 1'b1} << win_idx;
        end
      end
      BUSY: begin
        if (xfer_eop) begin
          state_d = IDLE;
          grant_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      ptr_q   <= PW'(NPORTS-1);
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
    end
  end

`ifdef PHIVERS_ARB_STALL_WDT_EN
  localparam int CW = $clog2(STALL_MAX + 1);

  logic [CW-1:0] idle_cnt_q;
  logic          stall_q;
  logic          starve;

  assign starve  = busy & ~tx_i[ptr_q];
  assign stall_o = stall_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idle_cnt_q <= '0;
      stall_q    <= 1'b0;
    end else begin
      if (!starve)
        idle_cnt_q <= '0;
      else if (idle_cnt_q != CW'(STALL_MAX))
        idle_cnt_q <= idle_cnt_q + 1'b1;
      // Flag rises on the same edge the count reaches STALL_MAX.
      if (starve && idle_cnt_q == CW'(STALL_MAX - 1))
        stall_q <= 1'b1;
    end
  end
`else
  assign stall_o = 1'b0 && (STALL_MAX > 0);
`endif

endmodule

// File: tb/tb_phivers_link_arbiter.sv
// Directed self-checking bench for phivers_link_arbiter (NPORTS=4, STALL_MAX=8).
module tb_phivers_link_arbiter;

  logic         clk = 1'b0;
  logic         rst_ni;
  logic [3:0]   tx_i;
  logic [3:0]   cr_tx_o;
  logic [3:0]   eop_tx_i;
  logic [127:0] data_tx_i;
  logic         rx_o;
  logic         cr_rx_i;
  logic         eop_rx_o;
  logic [31:0]  data_rx_o;
  logic [3:0]   grant_o;
  logic         busy_o;
  logic         stall_o;

  int n_chk = 0;
  int n_err = 0;

  phivers_link_arbiter #(.NPORTS(4), .STALL_MAX(8)) dut (
    .clk_i     (clk),
    .rst_ni    (rst_ni),
    .tx_i      (tx_i),
    .cr_tx_o   (cr_tx_o),
    .eop_tx_i  (eop_tx_i),
    .data_tx_i (data_tx_i),
    .rx_o      (rx_o),
    .cr_rx_i   (cr_rx_i),
    .eop_rx_o  (eop_rx_o),
    .data_rx_o (data_rx_o),
    .grant_o   (grant_o),
    .busy_o    (busy_o),
    .stall_o   (stall_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int p, input logic [31:0] v);
    data_tx_i[32*p +: 32] = v;
  endtask

  task automatic do_reset();
    rst_ni    = 1'b0;
    tx_i      = '0;
    eop_tx_i  = '0;
    data_tx_i = '0;
    cr_rx_i   = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_ni = 1'b1;
    nxt();
  endtask

  initial begin
    rst_ni    = 1'b0;
    tx_i      = '0;
    eop_tx_i  = '0;
    data_tx_i = '0;
    cr_rx_i   = 1'b0;
    @(negedge clk);
    check("rst_grant", grant_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_rx", rx_o, 0);
    check("rst_eop", eop_rx_o, 0);
    check("rst_data", data_rx_o, 0);
    check("rst_crtx", cr_tx_o, 0);
    check("rst_stall", stall_o, 0);
    @(negedge clk);
    rst_ni = 1'b1;
    nxt();

    // 3-flit packet on port 0
    tx_i    = 4'b0001;
    cr_rx_i = 1'b1;
    set_data(0, 32'hA0);
    #2;
    check("t1_idle_grant", grant_o, 0);
    check("t1_idle_crtx", cr_tx_o, 0);
    nxt(); #2;
    check("t1_grant", grant_o, 4'b0001);
    check("t1_rx0", rx_o, 1);
    check("t1_data0", data_rx_o, 32'hA0);
    check("t1_crtx", cr_tx_o, 4'b0001);
    check("t1_busy", busy_o, 1);
    nxt(); set_data(0, 32'hA1); #2;
    check("t1_data1", data_rx_o, 32'hA1);
    check("t1_eop1", eop_rx_o, 0);
    nxt(); set_data(0, 32'hA2); eop_tx_i = 4'b0001; #2;
    check("t1_data2", data_rx_o, 32'hA2);
    check("t1_eop2", eop_rx_o, 1);
    nxt(); tx_i = '0; eop_tx_i = '0; #2;
    check("t1_rel_grant", grant_o, 0);
    check("t1_rel_busy", busy_o, 0);

    // all ports request single-flit packets
    do_reset();
    tx_i     = 4'b1111;
    eop_tx_i = 4'b1111;
    for (int p = 0; p < 4; p++) set_data(p, 32'hB0 + p);
    for (int k = 0; k < 5; k++) begin
      nxt(); #2;
      check("t2_grant", grant_o, 32'd1 << (k % 4));
      check("t2_data", data_rx_o, 32'hB0 + (k % 4));
      nxt(); #2;
      check("t2_bubble", busy_o, 0);
    end
    tx_i = '0; eop_tx_i = '0;

    // port 2 with link credit withheld for 5 cycles
    tx_i = 4'b0100;
    set_data(2, 32'hC0);
    cr_rx_i = 1'b1;
    nxt(); #2;
    check("t3_grant", grant_o, 4'b0100);
    check("t3_data0", data_rx_o, 32'hC0);
    nxt(); set_data(2, 32'hC1); cr_rx_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #2;
      check("t3_hold_crtx", cr_tx_o, 0);
      check("t3_hold_grant", grant_o, 4'b0100);
      check("t3_hold_data", data_rx_o, 32'hC1);
      nxt();
    end
    cr_rx_i = 1'b1; eop_tx_i = 4'b0100; #2;
    check("t3_resume_crtx", cr_tx_o, 4'b0100);
    nxt(); tx_i = '0; eop_tx_i = '0; #2;
    check("t3_done", busy_o, 0);
    check("t3_stall", stall_o, 0);

    // port 1 granted; ports 0 and 3 queue behind it
    tx_i = 4'b0010;
    set_data(1, 32'hD0);
    nxt(); #2;
    check("t4_grant1", grant_o, 4'b0010);
    nxt(); tx_i = 4'b1011; eop_tx_i = 4'b1011; set_data(1, 32'hD1); #2;
    check("t4_hold", grant_o, 4'b0010);
    check("t4_data", data_rx_o, 32'hD1);
    nxt(); tx_i = 4'b1001; #2;
    check("t4_bubble", grant_o, 0);
    nxt(); #2;
    check("t4_next", grant_o, 4'b1000);
    nxt(); tx_i = '0; eop_tx_i = '0; #2;
    check("t4_done", grant_o, 0);

    // asynchronous reset during second flit of port 0
    tx_i = 4'b0001;
    set_data(0, 32'hE0);
    nxt(); #2;
    check("t5_grant", grant_o, 4'b0001);
    nxt(); set_data(0, 32'hE1); #2;
    check("t5_rx", rx_o, 1);
    rst_ni = 1'b0;
    #1;
    check("t5_rst_rx", rx_o, 0);
    check("t5_rst_crtx", cr_tx_o, 0);
    check("t5_rst_grant", grant_o, 0);
    check("t5_rst_busy", busy_o, 0);
    tx_i = '0;
    @(negedge clk);
    rst_ni = 1'b1;
    nxt();
    tx_i = 4'b0011; eop_tx_i = 4'b0011;
    nxt(); #2;
    check("t5_ptr_reset", grant_o, 4'b0001);
    nxt(); tx_i = '0; eop_tx_i = '0; #2;
    check("t5_done", busy_o, 0);

`ifdef PHIVERS_ARB_STALL_WDT_EN
    do_reset();
    tx_i = 4'b0001;
    nxt(); tx_i = '0;
    repeat (7) nxt();
    #2;
    check("t6_stall7", stall_o, 0);
    tx_i = 4'b0001;
    nxt(); tx_i = '0;
    repeat (7) nxt();
    #2;
    check("t6_stall7b", stall_o, 0);
    nxt(); #2;
    check("t6_stall8", stall_o, 1);
    check("t6_grant", grant_o, 4'b0001);
    tx_i = 4'b0001; eop_tx_i = 4'b0001;
    nxt(); tx_i = '0; eop_tx_i = '0; #2;
    check("t6_done", grant_o, 0);
    check("t6_sticky", stall_o, 1);
`else
    do_reset();
    tx_i = 4'b0001;
    nxt(); tx_i = '0;
    repeat (10) nxt();
    #2;
    check("t6_stall_tied", stall_o, 0);
    tx_i = 4'b0001; eop_tx_i = 4'b0001;
    nxt(); tx_i = '0; eop_tx_i = '0; #2;
    check("t6_done", grant_o, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
